// File: rtl/pc_gen_pkg.sv
// Shared constants and the next-pc select encoding for the fetch-stage PC generator.
package pc_gen_pkg;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b1;

    // Next-pc source, listed in descending priority (HOLD covers a stall with no flush).
    typedef enum logic [2:0] {
        PC_SEL_FLUSH,
        PC_SEL_BRANCH,
        PC_SEL_RAS,
        PC_SEL_PDT,
        PC_SEL_SEQ,
        PC_SEL_HOLD
    } pc_sel_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack with a saturating occupancy count.
// When full, a push overwrites the oldest entry; the count stays at RAS_DEPTH.
module ras_stack
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              clear,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic              w_pop_ok;

    assign w_ptr_inc = r_ptr + PTR_W'(1);
    assign w_pop_ok  = pop && (r_count != '0);
    assign empty     = (r_count == '0);
    assign top       = empty ? '0 : r_mem[r_ptr];

    // Stack state update: clear beats everything; push+pop on a non-empty stack replaces the top.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_count <= '0;
        end else if (push && w_pop_ok) begin
            r_mem[r_ptr] <= push_addr;
        end else if (push) begin
            r_mem[w_ptr_inc] <= push_addr;
            r_ptr            <= w_ptr_inc;
            if (r_count != CNT_FULL) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop_ok) begin
            r_ptr   <= r_ptr - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with a prioritised redirect network
// (flush > branch correction > RAS return > predictor > sequential) and a return-address stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int unsigned       STEP       = 4,
    parameter int unsigned       ALIGN_BITS = 1,
    parameter int unsigned       RAS_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              pdt_taken,
    input  logic [ADDR_W-1:0] pdt_target,
    input  logic              ras_push,
    input  logic [ADDR_W-1:0] ras_push_addr,
    input  logic              ras_pop,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
    localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);

    logic              r_ce;
    logic [ADDR_W-1:0] r_pc;
    logic              w_ras_act;
    logic              w_pop_hit;
    logic              w_unused_stall;
    pc_sel_e           w_sel;
    logic [ADDR_W-1:0] w_next_pc;

    // Only stall[0] applies to the fetch stage.
    assign w_unused_stall = ^stall[5:1];

    // RAS moves only on an enabled, unstalled, unflushed cycle; a branch correction does not block it.
    assign w_ras_act = (r_ce == ChipEnable) && !stall[0] && !flush;
    assign w_pop_hit = ras_pop && !ras_empty;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push && w_ras_act),
        .pop       (ras_pop && w_ras_act),
        .push_addr (ras_push_addr),
        .clear     (flush && (r_ce == ChipEnable)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // Select the next-pc source by priority and form the aligned target.
    always_comb begin
        w_sel     = PC_SEL_SEQ;
        w_next_pc = r_pc + STEP_V;
        if (flush) begin
            w_sel = PC_SEL_FLUSH;
        end else if (stall[0]) begin
            w_sel = PC_SEL_HOLD;
        end else if (branch_flag_i) begin
            w_sel = PC_SEL_BRANCH;
        end else if (w_pop_hit) begin
            w_sel = PC_SEL_RAS;
        end else if (pdt_taken) begin
            w_sel = PC_SEL_PDT;
        end
        case (w_sel)
            PC_SEL_FLUSH:  w_next_pc = flush_target & ALIGN_MASK;
            PC_SEL_BRANCH: w_next_pc = branch_target_address_i & ALIGN_MASK;
            PC_SEL_RAS:    w_next_pc = ras_top & ALIGN_MASK;
            PC_SEL_PDT:    w_next_pc = pdt_target & ALIGN_MASK;
            PC_SEL_HOLD:   w_next_pc = r_pc;
            default:       w_next_pc = r_pc + STEP_V;
        endcase
    end

    // Chip enable rises one edge after reset release; pc sits at RESET_VEC until then.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_ce <= ChipDisable;
            r_pc <= RESET_VEC;
        end else begin
            r_ce <= ChipEnable;
            if (r_ce == ChipDisable) begin
                r_pc <= RESET_VEC;
            end else begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign pc = r_pc;
    assign ce = r_ce;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default parameters).
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        pdt_taken;
    logic [31:0] pdt_target;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] ras_top;
    logic        ras_empty;

    int checks   = 0;
    int failures = 0;

    pc_gen #(
        .ADDR_W     (32),
        .RESET_VEC  (32'h0000_0000),
        .STEP       (4),
        .ALIGN_BITS (1),
        .RAS_DEPTH  (8)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .flush_target            (flush_target),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .pdt_taken               (pdt_taken),
        .pdt_target              (pdt_target),
        .ras_push                (ras_push),
        .ras_push_addr           (ras_push_addr),
        .ras_pop                 (ras_pop),
        .pc                      (pc),
        .ce                      (ce),
        .ras_top                 (ras_top),
        .ras_empty               (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = '0; flush = 1'b0; flush_target = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        pdt_taken = 1'b0; pdt_target = '0;
        ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        idle_inputs();
        rst = 1'b1;
        pdt_taken = 1'b1; pdt_target = 32'h0000_0500;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ce !== 1'b0 || pc !== 32'h0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: ce=%b pc=%h, expected ce=0 pc=00000000", i, ce, pc);
            end
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin
            failures++;
            $display("FAIL reset_ras: empty=%b top=%h, expected empty=1 top=00000000", ras_empty, ras_top);
        end
        pdt_taken = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (ce !== 1'b1 || pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: ce=%b pc=%h, expected ce=1 pc=00000000", ce, pc);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            checks++;
            if (pc !== exp_pc) begin
                failures++;
                $display("FAIL reset_seq%0d: pc=%h expected %h", i, pc, exp_pc);
            end
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        pdt_taken = 1'b1; pdt_target = 32'h0000_0100;
        tick();
        checks++;
        if (pc !== 32'h0000_0100) begin
            failures++;
            $display("FAIL prio_pdt: pc=%h expected 00000100", pc);
        end
        flush = 1'b1; flush_target = 32'h0000_0800;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h0000_0400;
        pdt_target = 32'h0000_0200;
        tick();
        checks++;
        if (pc !== 32'h0000_0800) begin
            failures++;
            $display("FAIL prio_flush: pc=%h expected 00000800", pc);
        end
        flush = 1'b0;
        branch_target_address_i = 32'h0000_0403;
        tick();
        checks++;
        if (pc !== 32'h0000_0402) begin
            failures++;
            $display("FAIL prio_branch_align: pc=%h expected 00000402", pc);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        idle_inputs();
        pdt_taken = 1'b1; pdt_target = 32'h0000_0040;
        ras_push = 1'b1; ras_push_addr = 32'h0000_0077;
        tick();
        checks++;
        if (pc !== 32'h0000_0040 || ras_top !== 32'h0000_0077 || ras_empty !== 1'b0) begin
            failures++;
            $display("FAIL stall_setup: pc=%h top=%h empty=%b, expected 00000040 00000077 0", pc, ras_top, ras_empty);
        end
        stall = 6'b000001;
        pdt_target = 32'h0000_0200;
        ras_push_addr = 32'h0000_0099;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== 32'h0000_0040 || ras_top !== 32'h0000_0077) begin
                failures++;
                $display("FAIL stall_hold%0d: pc=%h top=%h, expected 00000040 00000077", i, pc, ras_top);
            end
        end
        ras_push = 1'b0;
        flush = 1'b1; flush_target = 32'h0000_0900;
        tick();
        checks++;
        if (pc !== 32'h0000_0900 || ras_empty !== 1'b1 || ras_top !== 32'h0) begin
            failures++;
            $display("FAIL stall_flush: pc=%h empty=%b top=%h, expected 00000900 1 00000000", pc, ras_empty, ras_top);
        end
        idle_inputs();
    endtask

    task automatic test_ras_call_return();
        idle_inputs();
        ras_push = 1'b1; ras_push_addr = 32'h0000_0104;
        tick();
        checks++;
        if (pc !== 32'h0000_0904 || ras_top !== 32'h0000_0104) begin
            failures++;
            $display("FAIL ras_push1: pc=%h top=%h, expected 00000904 00000104", pc, ras_top);
        end
        ras_push_addr = 32'h0000_0208;
        tick();
        checks++;
        if (pc !== 32'h0000_0908 || ras_top !== 32'h0000_0208) begin
            failures++;
            $display("FAIL ras_push2: pc=%h top=%h, expected 00000908 00000208", pc, ras_top);
        end
        ras_push = 1'b0; ras_pop = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0000_0208 || ras_top !== 32'h0000_0104) begin
            failures++;
            $display("FAIL ras_pop1: pc=%h top=%h, expected 00000208 00000104", pc, ras_top);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_0104 || ras_empty !== 1'b1) begin
            failures++;
            $display("FAIL ras_pop2: pc=%h empty=%b, expected 00000104 1", pc, ras_empty);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_0108 || ras_empty !== 1'b1) begin
            failures++;
            $display("FAIL ras_pop_empty: pc=%h empty=%b, expected 00000108 1", pc, ras_empty);
        end
        idle_inputs();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_pc;
        idle_inputs();
        ras_push = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            ras_push_addr = 32'(i * 16);
            tick();
        end
        checks++;
        if (ras_top !== 32'h0000_0090 || ras_empty !== 1'b0) begin
            failures++;
            $display("FAIL ovf_top: top=%h empty=%b, expected 00000090 0", ras_top, ras_empty);
        end
        ras_push = 1'b0; ras_pop = 1'b1;
        exp_pc = 32'h0000_0090;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (pc !== exp_pc) begin
                failures++;
                $display("FAIL ovf_pop%0d: pc=%h expected %h", i, pc, exp_pc);
            end
            exp_pc = exp_pc - 32'h10;
        end
        checks++;
        if (ras_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drained: empty=%b expected 1", ras_empty);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_0024) begin
            failures++;
            $display("FAIL ovf_pop9_seq: pc=%h expected 00000024", pc);
        end
        idle_inputs();
    endtask

    task automatic test_wrap_push_pop();
        idle_inputs();
        pdt_taken = 1'b1; pdt_target = 32'hFFFF_FFFC;
        ras_push = 1'b1; ras_push_addr = 32'h0000_0300;
        tick();
        checks++;
        if (pc !== 32'hFFFF_FFFC || ras_top !== 32'h0000_0300) begin
            failures++;
            $display("FAIL wrap_setup: pc=%h top=%h, expected fffffffc 00000300", pc, ras_top);
        end
        idle_inputs();
        tick();
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_seq: pc=%h expected 00000000", pc);
        end
        ras_push = 1'b1; ras_push_addr = 32'h0000_0500; ras_pop = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0000_0300 || ras_top !== 32'h0000_0500 || ras_empty !== 1'b0) begin
            failures++;
            $display("FAIL pushpop: pc=%h top=%h empty=%b, expected 00000300 00000500 0", pc, ras_top, ras_empty);
        end
        ras_push = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0000_0500 || ras_empty !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_count: pc=%h empty=%b, expected 00000500 1", pc, ras_empty);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall();
        test_ras_call_return();
        test_ras_overflow();
        test_wrap_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
